// File: rtl/mips_trace_tx.sv
// Commit-trace transmitter: captures one retired-instruction record per cycle,
// stamps it with a free-running cycle count, buffers it in a small FIFO and
// serialises each record as a fixed 12-byte frame on a valid/ready byte stream.
module mips_trace_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CYCLE_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rec_valid,
    input  logic [31:0] rec_pc,
    input  logic [5:0]  rec_opcode,
    input  logic [5:0]  rec_funct,
    input  logic [31:0] rec_wd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]         cls;
        logic [CYCLE_W-1:0] stamp;
        logic [31:0]        pc;
        logic [31:0]        wd;
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    logic [CYCLE_W-1:0] cyc;
    rec_t               mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    rec_t               new_rec;
    rec_t               frame;
    state_t             state;
    logic [3:0]         idx;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               frame_done;

    // Byte i of the frame held in f; multi-byte fields go out little-endian.
    function automatic logic [7:0] frame_byte(input rec_t f, input logic [3:0] i);
        case (i)
            4'd0:    frame_byte = 8'hA5;
            4'd1:    frame_byte = {4'h0, f.cls};
            4'd2:    frame_byte = f.stamp[7:0];
            4'd3:    frame_byte = f.stamp[15:8];
            4'd4:    frame_byte = f.pc[7:0];
            4'd5:    frame_byte = f.pc[15:8];
            4'd6:    frame_byte = f.pc[23:16];
            4'd7:    frame_byte = f.pc[31:24];
            4'd8:    frame_byte = f.wd[7:0];
            4'd9:    frame_byte = f.wd[15:8];
            4'd10:   frame_byte = f.wd[23:16];
            4'd11:   frame_byte = f.wd[31:24];
            default: frame_byte = 8'h00;
        endcase
    endfunction

    // Classify the retiring instruction and build the record to be buffered.
    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        new_rec.cls   = 4'hF;
        new_rec.stamp = cyc;
        new_rec.pc    = rec_pc;
        new_rec.wd    = (rec_opcode == 6'd0) ? rec_wd : 32'h0;
        case (rec_opcode)
            6'd0: begin
                case (rec_funct)
                    6'd32:   new_rec.cls = 4'd0;
                    6'd34:   new_rec.cls = 4'd1;
                    6'd36:   new_rec.cls = 4'd2;
                    6'd37:   new_rec.cls = 4'd3;
                    default: new_rec.cls = 4'hF;
                endcase
            end
            6'd35:   new_rec.cls = 4'd4;
            6'd43:   new_rec.cls = 4'd5;
            6'd4:    new_rec.cls = 4'd6;
            6'd2:    new_rec.cls = 4'd7;
            default: new_rec.cls = 4'hF;
        endcase
    end

    // A full FIFO still accepts a record when the transmitter pops in the same cycle.
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign frame_done = (state == SEND) && tx_valid && tx_ready && (idx == 4'd11);
    assign pop        = !empty && ((state == IDLE) || frame_done);
    assign push       = rec_valid && (!full || pop);

    // Free-running cycle stamp, wrapping at the counter width.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) cyc <= '0;
        else      cyc <= cyc + CYCLE_W'(1);
    end

    // Record storage and the frame shift source.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy is tracked by count.
        if (push) mem[wr_ptr] <= new_rec;
        if (pop)  frame       <= mem[rd_ptr];
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (rec_valid && !push) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Frame serialiser FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= SEND;
                        idx      <= 4'd0;
                        tx_valid <= 1'b1;
                        tx_data  <= 8'hA5;
                        tx_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (idx != 4'd11) begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(frame, idx + 4'd1);
                            tx_last <= (idx == 4'd10);
                        end else if (pop) begin
                            idx     <= 4'd0;
                            tx_data <= 8'hA5;
                            tx_last <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            tx_last  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_trace_tx.sv
// Scoreboard bench for mips_trace_tx: stimulus pushes expected frame bytes,
// an independent monitor pops and compares every accepted stream byte.
module tb_mips_trace_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rec_valid;
    logic [31:0] rec_pc;
    logic [5:0]  rec_opcode;
    logic [5:0]  rec_funct;
    logic [31:0] rec_wd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        overflow;
    logic [7:0]  drop_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] tb_cyc;
    int          n_pushed = 0;
    int          frames_done = 0;
    int          rdy_mode = 0;

    mips_trace_tx #(.FIFO_DEPTH(DEPTH), .CYCLE_W(16)) dut (
        .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_pc(rec_pc),
        .rec_opcode(rec_opcode), .rec_funct(rec_funct), .rec_wd(rec_wd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference cycle count: cycles elapsed since reset release.
    always @(posedge clk) begin
        if (!rst) tb_cyc <= 16'd0;
        else      tb_cyc <= tb_cyc + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_class(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'd32) return 4'd0;
            if (fn == 6'd34) return 4'd1;
            if (fn == 6'd36) return 4'd2;
            if (fn == 6'd37) return 4'd3;
            return 4'hF;
        end
        if (op == 6'd35) return 4'd4;
        if (op == 6'd43) return 4'd5;
        if (op == 6'd4)  return 4'd6;
        if (op == 6'd2)  return 4'd7;
        return 4'hF;
    endfunction

    // Expected 12-byte frame, little-endian fields, last flag on byte 11.
    task automatic expect_frame(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] st,
                                input logic [31:0] pc, input logic [31:0] wd);
        logic [31:0] wdx;
        logic [7:0]  b [12];
        wdx  = (op == 6'd0) ? wd : 32'h0;
        b[0] = 8'hA5;
        b[1] = {4'h0, ref_class(op, fn)};
        for (int k = 0; k < 2; k++) b[2+k] = 8'((st  >> (8*k)) & 16'hFF);
        for (int k = 0; k < 4; k++) b[4+k] = 8'((pc  >> (8*k)) & 32'hFF);
        for (int k = 0; k < 4; k++) b[8+k] = 8'((wdx >> (8*k)) & 32'hFF);
        for (int k = 0; k < 12; k++) exp_q.push_back({(k == 11), b[k]});
    endtask

    // Drives one record for one cycle; returns at the start of the next cycle.
    task automatic push_rec(input logic [31:0] pc, input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] wd, input bit expected);
        rec_valid  = 1'b1;
        rec_pc     = pc;
        rec_opcode = op;
        rec_funct  = fn;
        rec_wd     = wd;
        if (expected) begin
            expect_frame(op, fn, tb_cyc, pc, wd);
            n_pushed++;
        end
        @(posedge clk); #1;
        rec_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int b = 0;
        while ((exp_q.size() != 0 || tx_valid) && b < budget) begin
            @(posedge clk); #1;
            b++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Sink readiness generator: always ready, 1-0-0-1 pattern, or random.
    initial begin
        int ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: compares accepted bytes, hold stability and in-frame continuity.
    initial begin
        int         byte_idx = 0;
        bit         held = 0;
        logic [7:0] held_data = 8'h00;
        logic       held_last = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                byte_idx = 0;
                held     = 0;
            end else begin
                if (held) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, held_data);
                    check("hold_last", tx_last, held_last);
                end else if (byte_idx != 0) begin
                    check("continuous_valid", tx_valid, 1);
                end
                if (tx_valid && tx_ready) begin
                    check("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("byte_data", tx_data, e[7:0]);
                        check("byte_last", tx_last, e[8]);
                    end
                    byte_idx = (byte_idx == 11) ? 0 : byte_idx + 1;
                    if (tx_last) frames_done++;
                end
                held      = tx_valid && !tx_ready;
                held_data = tx_data;
                held_last = tx_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rec_valid = 1'b0; rec_pc = '0; rec_opcode = '0; rec_funct = '0; rec_wd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);

        // ADD in the first cycle after release: latency and frame length.
        rst = 1'b1;
        push_rec(32'h0000_0004, 6'd0, 6'd32, 32'h0000_002A, 1);
        @(negedge clk);
        check("lat_n1_valid", tx_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", tx_valid, 1);
        check("lat_n2_data", tx_data, 8'hA5);
        repeat (11) @(negedge clk);
        check("byte11_last", tx_last, 1);
        @(negedge clk);
        check("idle_after_frame", tx_valid, 0);
        @(posedge clk); #1;

        // LW captured at stamp 0x0103.
        begin
            int b = 0;
            while (tb_cyc != 16'h0103 && b < 400) begin
                @(posedge clk); #1;
                b++;
            end
            check("lw_stamp_reached", tb_cyc, 16'h0103);
        end
        push_rec(32'h0040_0010, 6'd35, 6'd0, 32'hDEAD_BEEF, 1);
        wait_idle("drain_lw", 100);

        // Unknown opcode and J.
        push_rec(32'h0000_1000, 6'h08, 6'd32, 32'h1234_5678, 1);
        push_rec(32'h0000_2000, 6'd2, 6'd0, 32'hCAFE_F00D, 1);
        wait_idle("drain_unk_j", 100);

        // Backpressure with tx_ready pattern 1,0,0,1.
        rdy_mode = 1;
        push_rec(32'h8765_4320, 6'd0, 6'd34, 32'h0BAD_F00D, 1);
        wait_idle("drain_backpressure", 200);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Burst of 6: five contiguous frames, sixth record dropped.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push_rec(32'h0000_3000 + 32'(i * 4), 6'd0, 6'd36, 32'h100 + 32'(i), i < 5);
            end
            begin
                int b = 0;
                int c = 0;
                while (!tx_valid && b < 10) begin @(negedge clk); b++; end
                while (tx_valid && c < 100) begin c++; @(negedge clk); end
                check("burst_contiguous_cycles", c, 60);
            end
        join
        wait_idle("drain_burst", 200);
        check("burst_overflow", overflow, 1);
        check("burst_drop_count", drop_count, 1);

        // Randomised records under random backpressure, flow-controlled to avoid drops.
        rdy_mode = 2;
        for (int r = 0; r < 40; r++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         sel;
            int         b = 0;
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1, 2: op = 6'd0;
                3:       op = 6'd35;
                4:       op = 6'd43;
                5:       op = 6'd4;
                6:       op = 6'd2;
                default: op = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 4))
                0:       fn = 6'd32;
                1:       fn = 6'd34;
                2:       fn = 6'd36;
                3:       fn = 6'd37;
                default: fn = 6'($urandom_range(0, 63));
            endcase
            repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
            while ((n_pushed - frames_done) >= DEPTH && b < 2000) begin
                @(posedge clk); #1;
                b++;
            end
            check("flow_wait", b < 2000, 1);
            push_rec($urandom, op, fn, $urandom, 1);
        end
        wait_idle("drain_random", 4000);
        check("random_no_new_drops", drop_count, 1);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset asserted while frame byte 5 is on the stream.
        push_rec(32'h1122_3344, 6'd0, 6'd37, 32'h0000_0005, 1);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("byte5_before_reset", tx_data, 8'h33);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_drop_count", drop_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        push_rec(32'h0000_0040, 6'd43, 6'd0, 32'hFFFF_FFFF, 1);
        wait_idle("drain_after_reset", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
